// File: rtl/region_scan_controller_if.sv
// Signal bundle between the VGA counters / colour tracker and the region scan controller.
interface region_scan_controller_if;
    logic       enable;
    logic [9:0] x;
    logic [9:0] y;
    logic       detected;
    logic [1:0] region;
    logic [9:0] reg_min;
    logic [9:0] reg_max;
    logic [3:0] hit_mask;
    logic [1:0] active_region;
    logic       active_valid;
    logic       region_event;

    modport master (
        output enable, x, y, detected,
        input  region, reg_min, reg_max, hit_mask, active_region, active_valid, region_event
    );

    modport slave (
        input  enable, x, y, detected,
        output region, reg_min, reg_max, hit_mask, active_region, active_valid, region_event
    );
endinterface

// File: rtl/region_scan_controller.sv
// Round-robins one colour tracker over four screen regions, one region per frame,
// debounces each region's detection and publishes a stable active region.
module region_scan_controller #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int REGION_WIDTH = 160,
    parameter int HIT_VISITS   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    region_scan_controller_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, SCAN, COMMIT} state_t;

    localparam logic [9:0] RW      = 10'(REGION_WIDTH);
    localparam logic [9:0] RW_LAST = 10'(REGION_WIDTH - 1);
    localparam logic [9:0] X_LAST  = 10'(WIDTH - 1);
    localparam logic [9:0] Y_LAST  = 10'(HEIGHT - 1);
    localparam logic [2:0] HIT     = 3'(HIT_VISITS);

    state_t          r_state;
    state_t          w_stateNext;
    logic [1:0]      r_idx;
    logic [1:0]      w_idxNext;
    logic            r_detQ;
    logic [3:0][2:0] r_hitCnt;
    logic [3:0][2:0] w_hitCntNext;
    logic [3:0]      r_hitMask;
    logic [3:0]      w_hitMaskNext;
    logic [9:0]      r_regMin;
    logic [9:0]      r_regMax;
    logic [9:0]      w_minNext;
    logic [9:0]      w_maxNext;
    logic [1:0]      r_activeRegion;
    logic            r_activeValid;
    logic            r_regionEvent;
    logic [1:0]      w_lowest;
    logic            w_sof;
    logic            w_eof;
    logic            w_capture;
    logic            w_commit;

    assign w_sof = (bus.x == 10'd0) && (bus.y == 10'd0);
    assign w_eof = (bus.x == X_LAST) && (bus.y == Y_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A low enable parks the FSM in IDLE so a scan only ever starts on a full frame
    always_comb begin
        w_stateNext = r_state;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        if (!bus.enable) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE:     w_stateNext = WAIT_SOF;
                WAIT_SOF: if (w_sof) w_stateNext = SCAN;
                SCAN: begin
                    if (w_eof) begin
                        w_capture   = 1'b1;
                        w_stateNext = COMMIT;
                    end
                end
                COMMIT: begin
                    w_commit    = 1'b1;
                    w_stateNext = WAIT_SOF;
                end
                default:  w_stateNext = IDLE;
            endcase
        end
    end

    // Saturating per-region hit counters; the mask is built from the post-commit values
    always_comb begin
        w_hitCntNext = r_hitCnt;
        w_idxNext    = r_idx;
        if (w_commit) begin
            if (r_detQ) begin
                w_hitCntNext[r_idx] = (r_hitCnt[r_idx] >= HIT) ? HIT : r_hitCnt[r_idx] + 3'd1;
            end else begin
                w_hitCntNext[r_idx] = 3'd0;
            end
            w_idxNext = r_idx + 2'd1;
        end
        for (int i = 0; i < 4; i++) begin
            w_hitMaskNext[i] = (w_hitCntNext[i] == HIT);
        end
        w_minNext = 10'(w_idxNext) * RW;
        w_maxNext = w_minNext + RW_LAST;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx     <= 2'd0;
            r_detQ    <= 1'b0;
            r_hitCnt  <= '0;
            r_hitMask <= 4'd0;
            r_regMin  <= 10'd0;
            r_regMax  <= RW_LAST;
        end else if (!bus.enable) begin
            r_idx     <= 2'd0;
            r_detQ    <= 1'b0;
            r_hitCnt  <= '0;
            r_hitMask <= 4'd0;
            r_regMin  <= 10'd0;
            r_regMax  <= RW_LAST;
        end else begin
            r_idx     <= w_idxNext;
            r_hitCnt  <= w_hitCntNext;
            r_hitMask <= w_hitMaskNext;
            r_regMin  <= w_minNext;
            r_regMax  <= w_maxNext;
            if (w_capture) begin
                r_detQ <= bus.detected;
            end
        end
    end

    always_comb begin
        w_lowest = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_hitMask[i]) w_lowest = 2'(i);
        end
    end

    // The current winner is kept while it still hits; otherwise the lowest hitting region takes over
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_activeRegion <= 2'd0;
            r_activeValid  <= 1'b0;
            r_regionEvent  <= 1'b0;
        end else if (!bus.enable) begin
            r_activeRegion <= 2'd0;
            r_activeValid  <= 1'b0;
            r_regionEvent  <= 1'b0;
        end else if (r_activeValid && r_hitMask[r_activeRegion]) begin
            r_regionEvent <= 1'b0;
        end else if (r_hitMask != 4'd0) begin
            r_activeRegion <= w_lowest;
            r_activeValid  <= 1'b1;
            r_regionEvent  <= 1'b1;
        end else begin
            r_activeValid <= 1'b0;
            r_regionEvent <= 1'b0;
        end
    end

    assign bus.region        = r_idx;
    assign bus.reg_min       = r_regMin;
    assign bus.reg_max       = r_regMax;
    assign bus.hit_mask      = r_hitMask;
    assign bus.active_region = r_activeRegion;
    assign bus.active_valid  = r_activeValid;
    assign bus.region_event  = r_regionEvent;

endmodule
